// File: rtl/serial_frame_tx.sv
// Purpose: parallel-to-serial UART-style frame transmitter (start, data LSB-first, optional parity, stop).
// Latency: start bit appears the cycle after the accept edge; frame lasts (2+WIDTH+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: ready_out high only in IDLE; one IDLE cycle separates back-to-back frames.
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int PARITY_EN    = 1,
    parameter int ODD_PARITY   = 0,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       r_state;
    logic [TW-1:0]    r_tick;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_data;
    logic             r_parity;

    logic [2:0]       w_state_nxt;
    logic [TW-1:0]    w_tick_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_ser_nxt;
    logic             w_accept;
    logic             w_wrap;

    assign w_accept = valid_in && ready_out;
    assign w_wrap   = (r_tick == TICK_LAST);

    // Next-state, tick and bit-index logic; the index only moves on a tick wrap
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_idx_nxt   = r_idx;
        if (r_state != S_IDLE) begin
            w_tick_nxt = w_wrap ? '0 : r_tick + TW'(1);
        end
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_tick_nxt  = '0;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from where the FSM is heading
    always_comb begin
        w_ser_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_ser_nxt = 1'b0;
            S_DATA:   w_ser_nxt = r_data[w_idx_nxt];
            S_PARITY: w_ser_nxt = r_parity;
            default:  w_ser_nxt = 1'b1;
        endcase
    end

    // State, counters, captured word and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_parity   <= 1'b0;
            serial_out <= 1'b1;
            ready_out  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick     <= w_tick_nxt;
            r_idx      <= w_idx_nxt;
            if (w_accept) begin
                r_data   <= data_in;
                r_parity <= (^data_in) ^ 1'(ODD_PARITY);
            end
            serial_out <= w_ser_nxt;
            ready_out  <= (w_state_nxt == S_IDLE);
            busy       <= (w_state_nxt != S_IDLE);
            frame_done <= (r_state == S_STOP) && w_wrap;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: five parameterisations driven with directed and random words,
// each frame compared cycle-by-cycle against a bit-list model built from the framing rules.
module tb_serial_frame_tx;

    logic        clk;
    logic        rst;
    logic [11:0] r_din;
    logic        r_vld  [5];
    logic        w_rdy  [5];
    logic        w_ser  [5];
    logic        w_busy [5];
    logic        w_done [5];

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0), .CLKS_PER_BIT(1)) u_dut0 (
        .clock(clk), .reset(rst), .data_in(r_din[7:0]), .valid_in(r_vld[0]),
        .ready_out(w_rdy[0]), .serial_out(w_ser[0]), .busy(w_busy[0]), .frame_done(w_done[0]));
    serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(1), .CLKS_PER_BIT(1)) u_dut1 (
        .clock(clk), .reset(rst), .data_in(r_din[7:0]), .valid_in(r_vld[1]),
        .ready_out(w_rdy[1]), .serial_out(w_ser[1]), .busy(w_busy[1]), .frame_done(w_done[1]));
    serial_frame_tx #(.WIDTH(8), .PARITY_EN(0), .ODD_PARITY(0), .CLKS_PER_BIT(1)) u_dut2 (
        .clock(clk), .reset(rst), .data_in(r_din[7:0]), .valid_in(r_vld[2]),
        .ready_out(w_rdy[2]), .serial_out(w_ser[2]), .busy(w_busy[2]), .frame_done(w_done[2]));
    serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0), .CLKS_PER_BIT(3)) u_dut3 (
        .clock(clk), .reset(rst), .data_in(r_din[7:0]), .valid_in(r_vld[3]),
        .ready_out(w_rdy[3]), .serial_out(w_ser[3]), .busy(w_busy[3]), .frame_done(w_done[3]));
    serial_frame_tx #(.WIDTH(12), .PARITY_EN(1), .ODD_PARITY(1), .CLKS_PER_BIT(2)) u_dut4 (
        .clock(clk), .reset(rst), .data_in(r_din), .valid_in(r_vld[4]),
        .ready_out(w_rdy[4]), .serial_out(w_ser[4]), .busy(w_busy[4]), .frame_done(w_done[4]));

    function automatic int cfg_w(input int d);
        return (d == 4) ? 12 : 8;
    endfunction
    function automatic int cfg_p(input int d);
        return (d == 2) ? 0 : 1;
    endfunction
    function automatic int cfg_o(input int d);
        return (d == 1 || d == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_c(input int d);
        return (d == 3) ? 3 : ((d == 4) ? 2 : 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line levels for one frame, one entry per clock cycle
    task automatic build_exp(input int d, input logic [15:0] word, input bit append);
        int  c;
        bit  par;
        c = cfg_c(d);
        if (!append) exp_q.delete();
        par = 1'(cfg_o(d));
        for (int b = 0; b < cfg_w(d); b++) par ^= word[b];
        for (int k = 0; k < c; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < cfg_w(d); b++)
            for (int k = 0; k < c; k++) exp_q.push_back(word[b]);
        if (cfg_p(d) != 0)
            for (int k = 0; k < c; k++) exp_q.push_back(par);
        for (int k = 0; k < c; k++) exp_q.push_back(1'b1);
    endtask

    task automatic send_frame(input int d, input logic [15:0] word);
        logic [3:0] sr;
        int         w;
        w  = cfg_w(d);
        sr = 4'b0000;
        @(negedge clk);
        r_din    = word[11:0];
        r_vld[d] = 1'b1;
        chk($sformatf("pre_rdy d%0d", d), 32'(w_rdy[d]), 32'd1);
        @(negedge clk);
        r_vld[d] = 1'b0;
        build_exp(d, word, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("ser d%0d w%0h c%0d", d, word, i + 1), 32'(w_ser[d]), 32'(exp_q[i]));
            chk($sformatf("busy d%0d c%0d", d, i + 1), 32'(w_busy[d]), 32'd1);
            chk($sformatf("rdy d%0d c%0d", d, i + 1), 32'(w_rdy[d]), 32'd0);
            chk($sformatf("done d%0d c%0d", d, i + 1), 32'(w_done[d]), 32'd0);
            sr = {w_ser[d], sr[3:1]};
            if (cfg_c(d) == 1 && i == w)
                chk($sformatf("shift4 d%0d w%0h", d, word), 32'(sr), 32'(word[w-1 -: 4]));
            @(negedge clk);
        end
        chk($sformatf("done_pulse d%0d", d), 32'(w_done[d]), 32'd1);
        chk($sformatf("idle_rdy d%0d", d), 32'(w_rdy[d]), 32'd1);
        chk($sformatf("idle_busy d%0d", d), 32'(w_busy[d]), 32'd0);
        chk($sformatf("idle_ser d%0d", d), 32'(w_ser[d]), 32'd1);
        @(negedge clk);
        chk($sformatf("done_once d%0d", d), 32'(w_done[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;
        rst   = 1'b0;
        r_din = '0;
        for (int d = 0; d < 5; d++) r_vld[d] = 1'b0;

        // Asynchronous reset mid-cycle, then idle
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 5; d++) begin
            chk($sformatf("rst_ser d%0d", d), 32'(w_ser[d]), 32'd1);
            chk($sformatf("rst_rdy d%0d", d), 32'(w_rdy[d]), 32'd1);
            chk($sformatf("rst_busy d%0d", d), 32'(w_busy[d]), 32'd0);
            chk($sformatf("rst_done d%0d", d), 32'(w_done[d]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 5; d++) begin
                chk($sformatf("idle_ser d%0d", d), 32'(w_ser[d]), 32'd1);
                chk($sformatf("idle_rdy d%0d", d), 32'(w_rdy[d]), 32'd1);
                chk($sformatf("idle_busy d%0d", d), 32'(w_busy[d]), 32'd0);
                chk($sformatf("idle_done d%0d", d), 32'(w_done[d]), 32'd0);
            end
        end

        // Directed frames
        send_frame(0, 16'h00A5);
        send_frame(0, 16'h0007);
        send_frame(1, 16'h00A5);
        send_frame(2, 16'h0080);
        send_frame(3, 16'h0001);
        send_frame(4, 16'h0A5C);

        // Back-to-back: valid held high, 0x55 then 0xFF
        @(negedge clk);
        r_din    = 12'h055;
        r_vld[0] = 1'b1;
        @(negedge clk);
        r_din = 12'h0FF;
        build_exp(0, 16'h0055, 1'b0);
        exp_q.push_back(1'b1);
        build_exp(0, 16'h00FF, 1'b1);
        c1 = -1;
        c2 = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("b2b_ser c%0d", i + 1), 32'(w_ser[0]), 32'(exp_q[i]));
            chk($sformatf("b2b_rdy c%0d", i + 1), 32'(w_rdy[0]), (i == 11) ? 32'd1 : 32'd0);
            if (w_ser[0] == 1'b0 && c1 < 0) c1 = i;
            if (w_ser[0] == 1'b0 && i >= 11 && c2 < 0) c2 = i;
            if (i == 12) r_vld[0] = 1'b0;
            @(negedge clk);
        end
        chk("b2b_gap", 32'(c2 - c1), 32'd12);
        chk("b2b_done", 32'(w_done[0]), 32'd1);
        @(negedge clk);

        // Abort during data bit 3 of 0x3C
        r_din    = 12'h03C;
        r_vld[0] = 1'b1;
        @(negedge clk);
        r_vld[0] = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("abort_pre_ser", 32'(w_ser[0]), 32'd1);
        chk("abort_pre_busy", 32'(w_busy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ser", 32'(w_ser[0]), 32'd1);
        chk("abort_busy", 32'(w_busy[0]), 32'd0);
        chk("abort_rdy", 32'(w_rdy[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(w_done[0]), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_nodone", 32'(w_done[0]), 32'd0);
            chk("post_abort_ser", 32'(w_ser[0]), 32'd1);
        end
        send_frame(0, 16'h0081);

        // Abort during the start bit: line must return high asynchronously
        @(negedge clk);
        r_din    = 12'h000;
        r_vld[2] = 1'b1;
        @(negedge clk);
        r_vld[2] = 1'b0;
        chk("abort2_start", 32'(w_ser[2]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort2_ser", 32'(w_ser[2]), 32'd1);
        chk("abort2_busy", 32'(w_busy[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(2, 16'h0000);

        // Random words on every configuration
        for (int d = 0; d < 5; d++) begin
            for (int k = 0; k < 6; k++) begin
                logic [15:0] word;
                word = 16'($urandom_range(0, (1 << cfg_w(d)) - 1));
                send_frame(d, word);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter that feeds the serial input of the 4-bit shift stage. It accepts a WIDTH-bit word over a valid/ready handshake. It then emits a UART-style frame on `serial_out`: start bit, data LSB-first, optional parity bit, stop bit. It drives the line on the rising edge of `clock`, so each level is stable half a cycle before the downstream stage samples on the falling edge.

## Interface
- `WIDTH`, 8: data bits per frame (1..16).
- `PARITY_EN`, 1: 1 inserts a parity bit after the data; 0 omits it.
- `ODD_PARITY`, 0: 0 selects even parity, 1 selects odd (ignored when `PARITY_EN`=0).
- `CLKS_PER_BIT`, 1: clock cycles each bit level is held (1..255).
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `data_in` input WIDTH: word to transmit; sampled only on the accept edge.
- `valid_in` input 1: upstream offers `data_in`.
- `ready_out` output 1: block can accept; high only in IDLE.
- `serial_out` output 1: serial line; idle level 1.
- `busy` output 1: high while a frame is in progress (any state except IDLE).
- `frame_done` output 1: one-cycle pulse when a frame completes.

## Operation
- Reset values: state IDLE, `serial_out`=1, `ready_out`=1, `busy`=0, `frame_done`=0, bit and tick counters 0, data register 0.
- Accept: on a rising edge with `valid_in`=1 and `ready_out`=1:
  - latch `data_in` into the data register;
  - compute parity as the XOR of the data bits, inverted when `ODD_PARITY`=1;
  - go to START.
  - Later changes on `data_in` or `valid_in` have no effect until IDLE.
- FSM states and transitions:
  - IDLE: `serial_out`=1. Go to START on accept.
  - START: `serial_out`=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: `serial_out` = data[index] for CLKS_PER_BIT cycles per bit, index 0 through WIDTH-1. After the last bit, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: `serial_out` = the parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `serial_out`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Tick counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. The bit index advances only at a wrap.
- Counter widths: the tick counter is sized to hold CLKS_PER_BIT-1; the bit index is sized to hold WIDTH-1. No arithmetic overflow is permitted.
- `frame_done` is asserted, registered, in the first cycle back in IDLE, for exactly one cycle.
- `valid_in` held high with `ready_out`=1 in IDLE: the next frame is accepted on that edge. Back-to-back frames have no idle gap beyond that one IDLE cycle.
- `valid_in` low in IDLE: the line stays at 1 indefinitely.
- Reset asserted mid-frame:
  - abort immediately (asynchronously);
  - `serial_out` goes to 1 and `busy` to 0;
  - no `frame_done` pulse;
  - the partial word is discarded;
  - the first edge after reset release is treated as IDLE.

## Timing
- Latency: `serial_out` drops to 0 (start bit) in the cycle after the accept edge.
- Frame length is (1 + WIDTH + PARITY_EN + 1) × CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- Defaults: 11 cycles per frame; the accept-to-accept minimum is 12 cycles (frame plus the IDLE cycle).
- `ready_out` falls on the accept edge and rises on the edge that enters IDLE, the same edge that asserts `frame_done`.
- `busy` is high exactly during START, DATA, PARITY and STOP.
- All outputs are registered; none is a combinational function of the inputs.

## Test plan
- Reset then idle:
  - stimulus: assert `reset` asynchronously mid-cycle; release; hold `valid_in`=0 for 20 cycles;
  - required: `serial_out`=1, `ready_out`=1, `busy`=0, `frame_done`=0 throughout.
- 0xA5, defaults:
  - stimulus: send 0xA5;
  - required `serial_out` per cycle after accept: 0,1,0,1,0,0,1,0,1,0,1 (even parity bit 0);
  - required: `frame_done` pulses on cycle 12; the downstream shift stage then holds 4'b1010 after the last four bits.
- Parity modes:
  - stimulus: send 0x07 with even parity;
  - required: parity bit 1;
  - stimulus: send 0xA5 with `ODD_PARITY`=1;
  - required: parity bit 1;
  - stimulus: send with `PARITY_EN`=0;
  - required: a 10-bit frame ending 0x80's MSB=1 followed by the stop bit.
- Bit stretching:
  - stimulus: `CLKS_PER_BIT`=3, send 0x01;
  - required: the start level is held 3 cycles, the data bit 1 is held 3 cycles, and the frame totals 33 cycles.
- Back-to-back:
  - stimulus: `valid_in` held high with 0x55 then 0xFF;
  - required: the second start bit appears exactly 12 cycles after the first;
  - required: `ready_out` is high only in the single IDLE cycle between the two frames.
- Abort:
  - stimulus: assert `reset` during data bit 3 of 0x3C;
  - required: `serial_out`=1 immediately, `busy`=0, no `frame_done`;
  - stimulus: after release, send 0x81;
  - required: a clean, complete frame.
